// File: rtl/yuv422_to_rgb_stream.sv
// YUYV 4:2:2 AXI4-Stream to RGB AXI4-Stream converter (inverse BT.601, full range).
// Chroma terms are computed once per pair and queued; the output stage emits pixel0 then pixel1.
module yuv422_to_rgb_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [2*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tuser,
  input  logic                      s_axis_tlast,
  output logic [3*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      resync_err,
  output logic                      dbg_phase
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = DATA_WIDTH + 10;
  localparam int TW = DATA_WIDTH + 2;
  localparam logic [DW-1:0] OFFSET = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAXV = '1;
  localparam logic signed [PW-1:0] K_RV = 359;
  localparam logic signed [PW-1:0] K_GU = 88;
  localparam logic signed [PW-1:0] K_GV = 183;
  localparam logic signed [PW-1:0] K_BU = 454;

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

  typedef struct packed {
    logic [DW-1:0]        y0;
    logic [DW-1:0]        y1;
    logic signed [TW-1:0] tr;
    logic signed [TW-1:0] tg;
    logic signed [TW-1:0] tb;
    logic                 user;
    logic                 last;
    logic                 lone;
  } pair_t;

  // Handshake: a beat moves on either side only on a cycle where tvalid & tready are both high.
  phase_t             r_phase, w_phase_nxt;
  logic               r_run;
  logic [DW-1:0]      r_y0, r_u;
  logic               r_user;
  pair_t              r_fifo [2];
  logic               r_wr_ptr, r_rd_ptr;
  logic [1:0]         r_count;
  logic               r_out_valid, r_out_user, r_out_last, r_pix_sel;
  logic [3*DW-1:0]    r_out_data;
  logic               r_resync;

  logic [DW-1:0]        w_in_y, w_in_c, w_pu, w_pv, w_y_sel;
  logic                 w_in_fire, w_as_even, w_push, w_pop, w_resync;
  logic                 w_out_free, w_load;
  logic signed [PW-1:0] w_du, w_dv, w_pr, w_pg, w_pb;
  pair_t                w_new, w_head;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] y,
                                            input logic signed [TW-1:0] t);
    logic signed [TW-1:0] s;
    s = $signed({2'b00, y}) + t;
    if (s < 0) return '0;
    else if (s > $signed({2'b00, MAXV})) return MAXV;
    else return s[DW-1:0];
  endfunction

  assign w_in_y    = s_axis_tdata[DW-1:0];
  assign w_in_c    = s_axis_tdata[2*DW-1:DW];
  assign w_in_fire = s_axis_tvalid & s_axis_tready;
  // A start-of-frame beat always restarts the pair, whatever phase we are in.
  assign w_as_even = (r_phase == EVEN) | s_axis_tuser;
  assign w_push    = w_in_fire & (~w_as_even | s_axis_tlast);
  assign w_resync  = w_in_fire & (r_phase == ODD) & s_axis_tuser;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_phase <= EVEN;
    else        r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_in_fire) begin
      if (w_as_even && !s_axis_tlast) w_phase_nxt = ODD;
      else                            w_phase_nxt = EVEN;
    end
  end

  // A lone pixel at end of line uses neutral V.
  assign w_pu = w_as_even ? w_in_c : r_u;
  assign w_pv = w_as_even ? OFFSET : w_in_c;
  assign w_du = PW'(w_pu) - PW'(OFFSET);
  assign w_dv = PW'(w_pv) - PW'(OFFSET);
  assign w_pr = w_dv * K_RV;
  assign w_pg = -(w_du * K_GU) - (w_dv * K_GV);
  assign w_pb = w_du * K_BU;

  always_comb begin
    w_new      = '0;
    w_new.y0   = w_as_even ? w_in_y : r_y0;
    w_new.y1   = w_in_y;
    w_new.tr   = TW'(w_pr >>> 8);
    w_new.tg   = TW'(w_pg >>> 8);
    w_new.tb   = TW'(w_pb >>> 8);
    w_new.user = w_as_even ? s_axis_tuser : r_user;
    w_new.last = s_axis_tlast;
    w_new.lone = w_as_even;
  end

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_out_free = ~r_out_valid | m_axis_tready;
  assign w_load     = w_out_free & (r_count != 2'd0);
  assign w_pop      = w_load & (r_pix_sel | w_head.lone);
  assign w_y_sel    = r_pix_sel ? w_head.y1 : w_head.y0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_run    <= 1'b0;
      r_y0     <= '0;
      r_u      <= '0;
      r_user   <= 1'b0;
      r_resync <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire && w_as_even) begin
        r_y0   <= w_in_y;
        r_u    <= w_in_c;
        r_user <= s_axis_tuser;
      end
      if (w_resync) r_resync <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_new;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= 1'b0;
      r_out_last  <= 1'b0;
      r_pix_sel   <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_out_data <= {sat_add(w_y_sel, w_head.tr), sat_add(w_y_sel, w_head.tg),
                       sat_add(w_y_sel, w_head.tb)};
        r_out_user <= ~r_pix_sel & w_head.user;
        r_out_last <= w_head.last & (r_pix_sel | w_head.lone);
        r_pix_sel  <= ~w_pop;
      end
    end
  end

  // Ready depends only on registered occupancy, never on m_axis_tready.
  assign s_axis_tready = r_run & (r_count != 2'd2);
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tuser  = r_out_user;
  assign m_axis_tlast  = r_out_last;
  assign resync_err    = r_resync;
  assign dbg_phase     = r_phase;

endmodule

// File: tb/tb_yuv422_to_rgb_stream.sv
// Bench for yuv422_to_rgb_stream: arithmetic reference model feeding an expected queue,
// with an independent output monitor that pops and compares on every output handshake.
module tb_yuv422_to_rgb_stream;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        resync_err;
  logic        dbg_phase;

  yuv422_to_rgb_stream #(.DATA_WIDTH(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .resync_err(resync_err), .dbg_phase(dbg_phase)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [25:0] exp_q[$];
  bit          md_have_even = 0;
  logic [7:0]  md_y0, md_u;
  bit          md_user;
  bit          exp_resync = 0;

  function automatic int fdiv256(input int a);
    if (a >= 0) return a / 256;
    else return -((-a + 255) / 256);
  endfunction

  function automatic logic [7:0] sat8(input int v);
    if (v < 0) return 8'd0;
    else if (v > 255) return 8'd255;
    else return 8'(v);
  endfunction

  function automatic logic [23:0] to_rgb(input int y, input int u, input int v);
    int du, dv;
    du = u - 128;
    dv = v - 128;
    return {sat8(y + fdiv256(359 * dv)),
            sat8(y + fdiv256(-88 * du - 183 * dv)),
            sat8(y + fdiv256(454 * du))};
  endfunction

  task automatic model_beat(input logic [7:0] y, input logic [7:0] c,
                            input logic user, input logic last);
    if (md_have_even && !user) begin
      exp_q.push_back({1'b0, md_user, to_rgb(md_y0, md_u, c)});
      exp_q.push_back({last, 1'b0, to_rgb(y, md_u, c)});
      md_have_even = 0;
    end else begin
      if (md_have_even && user) exp_resync = 1;
      if (last) begin
        exp_q.push_back({1'b1, user, to_rgb(y, c, 128)});
        md_have_even = 0;
      end else begin
        md_have_even = 1;
        md_y0 = y;
        md_u = c;
        md_user = user;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called aligned just after a rising edge; returns aligned just after the accepting edge.
  task automatic send_beat(input logic [7:0] y, input logic [7:0] c,
                           input logic user, input logic last);
    int n;
    bit ok;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {c, y};
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    n = 0;
    ok = 0;
    while (n < 1000) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
      n++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL s_ready_timeout got 0 expected 1");
    end
    @(posedge aclk);
    #1;
    if (ok) model_beat(y, c, user, last);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [25:0] got_w, exp_w, prev_w;
  bit          prev_valid = 0, prev_ready = 0;
  int          out_hs = 0, user_cyc = 0, last_cyc = 0;

  always @(negedge aclk) begin
    got_w = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    if (areset) begin
      prev_valid = 0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!m_axis_tvalid || got_w !== prev_w) begin
          errors++;
          $display("FAIL stall_hold got v=%0b %h expected v=1 %h", m_axis_tvalid, got_w, prev_w);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_hs++;
        if (m_axis_tuser) user_cyc = cyc;
        if (m_axis_tlast) last_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel got %h expected none", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            errors++;
            $display("FAIL pixel got %h expected %h", got_w, exp_w);
          end
        end
      end
      prev_valid = m_axis_tvalid;
      prev_ready = m_axis_tready;
      prev_w     = got_w;
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int hs0, len;
    repeat (3) @(negedge aclk);
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_data", m_axis_tdata, 0);
    check("rst_m_user", m_axis_tuser, 0);
    check("rst_m_last", m_axis_tlast, 0);
    check("rst_resync", resync_err, 0);
    ready_mode = 1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("ready_pre_edge", s_axis_tready, 0);
    @(posedge aclk);
    #1;
    check("ready_post_edge", s_axis_tready, 1);

    // neutral grey with latency checks
    send_beat(8'd128, 8'd128, 1'b1, 1'b0);
    send_beat(8'd128, 8'd128, 1'b0, 1'b0);
    check("lat_n_valid", m_axis_tvalid, 0);
    @(posedge aclk); #1;
    check("lat_p0_valid", m_axis_tvalid, 1);
    check("lat_p0_data", m_axis_tdata, 24'h808080);
    check("lat_p0_user", m_axis_tuser, 1);
    @(posedge aclk); #1;
    check("lat_p1_valid", m_axis_tvalid, 1);
    check("lat_p1_data", m_axis_tdata, 24'h808080);
    check("lat_p1_user", m_axis_tuser, 0);
    send_beat(8'd255, 8'd128, 1'b0, 1'b0);
    send_beat(8'd255, 8'd128, 1'b0, 1'b0);
    wait_drain();

    // saturation corners
    send_beat(8'd0, 8'd128, 1'b0, 1'b0);
    send_beat(8'd0, 8'd255, 1'b0, 1'b0);
    @(posedge aclk); #1;
    check("sat_red", m_axis_tdata, 24'hB20000);
    send_beat(8'd255, 8'd0, 1'b0, 1'b0);
    send_beat(8'd255, 8'd0, 1'b0, 1'b0);
    @(posedge aclk); #1;
    check("sat_mixed", m_axis_tdata, 24'h4BFF1C);
    wait_drain();

    // full 640-beat line at full rate
    hs0 = out_hs;
    for (int i = 0; i < 640; i++)
      send_beat(8'($urandom), 8'($urandom), i == 0, i == 639);
    wait_drain();
    check("line_pixels", out_hs - hs0, 640);
    check("line_span", last_cyc - user_cyc, 639);

    // odd-length line ends on a lone pixel; next beat restarts EVEN
    send_beat(8'd40, 8'd200, 1'b1, 1'b0);
    send_beat(8'd90, 8'd30, 1'b0, 1'b0);
    send_beat(8'd150, 8'd60, 1'b0, 1'b1);
    check("lone_phase_even", dbg_phase, 0);
    send_beat(8'd10, 8'd250, 1'b0, 1'b0);
    send_beat(8'd220, 8'd5, 1'b0, 1'b1);
    wait_drain();

    // random backpressure and input gaps over 10 lines
    ready_mode = 2;
    for (int ln = 0; ln < 10; ln++) begin
      len = $urandom_range(1, 48);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk); #1;
        end
        send_beat(8'($urandom), 8'($urandom), (i == 0) && (ln % 3 == 0), i == len - 1);
      end
    end
    ready_mode = 1;
    wait_drain();

    // start-of-frame in ODD phase drops the held even beat
    check("resync_before", resync_err, exp_resync);
    send_beat(8'd10, 8'd20, 1'b0, 1'b0);
    send_beat(8'd30, 8'd40, 1'b1, 1'b0);
    check("resync_set", resync_err, exp_resync);
    send_beat(8'd50, 8'd60, 1'b0, 1'b1);
    wait_drain();
    check("resync_sticky", resync_err, 1);

    // reset mid-line with pixels stalled in flight
    ready_mode = 0;
    @(posedge aclk); #1;
    send_beat(8'd77, 8'd99, 1'b1, 1'b0);
    send_beat(8'd88, 8'd11, 1'b0, 1'b0);
    @(posedge aclk); #1;
    check("pre_rst_valid", m_axis_tvalid, 1);
    areset = 1'b1;
    #1;
    check("mid_rst_valid", m_axis_tvalid, 0);
    check("mid_rst_data", m_axis_tdata, 0);
    check("mid_rst_user", m_axis_tuser, 0);
    check("mid_rst_resync", resync_err, 0);
    check("mid_rst_s_ready", s_axis_tready, 0);
    exp_q.delete();
    md_have_even = 0;
    exp_resync = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    ready_mode = 1;
    @(posedge aclk); #1;
    check("post_rst_phase", dbg_phase, 0);
    for (int i = 0; i < 8; i++)
      send_beat(8'($urandom), 8'($urandom), i == 0, i == 7);
    wait_drain();
    check("post_rst_resync", resync_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yuv422_to_rgb_stream.md
# yuv422_to_rgb_stream

Streaming YUV 4:2:2 (YUYV) to RGB converter for the image data converter path. It accepts AXI4-Stream video beats of packed luma/chroma pairs and performs the inverse BT.601 full-range transform. It emits one RGB pixel per beat on an AXI4-Stream master, forwarding start-of-frame and end-of-line markers. It sits between the camera/frame-buffer read side and the display/DMA RGB consumers.

## Interface
- DATA_WIDTH, 8, bits per colour component; chroma offset = 2^(DATA_WIDTH-1), saturation max = 2^DATA_WIDTH-1
- aclk  in  1  clock, all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  2*DATA_WIDTH  [DATA_WIDTH-1:0]=Y, [2*DATA_WIDTH-1:DATA_WIDTH]=U on even beat, V on odd beat
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when valid&ready
- s_axis_tuser  in  1  start of frame, on first beat of frame
- s_axis_tlast  in  1  end of line
- m_axis_tdata  out  3*DATA_WIDTH  {R,G,B}, R in MSBs
- m_axis_tvalid  out  1  output pixel valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  start of frame
- m_axis_tlast  out  1  end of line
- resync_err  out  1  sticky; set when a held even beat is discarded

## Operation
- Phase FSM, states EVEN (expect Y0,U) / ODD (expect Y1,V); reset -> EVEN.
- EVEN beat accepted: latch Y0, U, tuser; -> ODD. If tlast also set: lone pixel, V = offset, pair issued as single pixel, stay EVEN.
- ODD beat accepted: latch Y1, V, tlast; pair issued; -> EVEN.
- Beat with tuser=1 accepted in ODD: held Y0/U discarded, resync_err set, beat treated as EVEN.
- Arithmetic, per pair: dU = U-offset, dV = V-offset (signed DATA_WIDTH+1). Terms computed once per pair, shared by both pixels: r = 359*dV, g = -88*dU - 183*dV, b = 454*dU. Each term arithmetic-shifted right by 8 (floor). Pixel = Y + term, signed, then saturated to [0, 2^DATA_WIDTH-1].
- Output order: pixel0 (Y0), then pixel1 (Y1). m_axis_tuser=1 only on pixel0 of a pair whose EVEN beat had tuser. m_axis_tlast=1 only on the final pixel of a pair whose line-ending beat had tlast (pixel1, or the lone pixel).
- Standard AXI-Stream rules: m_axis_tdata/tuser/tlast stable while tvalid & !tready; tvalid never drops without a handshake.

## Timing
- Reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, resync_err=0, FSM=EVEN, all pair buffers empty. s_axis_tready rises on the first aclk edge after areset deasserts.
- Latency: ODD beat accepted at edge N -> chroma terms registered at N -> pixel0 on m_axis after edge N+1 -> pixel1 after edge N+2 (if pixel0 handshaken at N+2).
- Throughput: with m_axis_tready held 1, sustained 1 input beat and 1 output pixel per clock, with no bubbles across pairs or lines.
- Buffering: at least one complete pair queued behind the pair being output. s_axis_tready is derived from registered occupancy only, with no combinational path from m_axis_tready.
- Backpressure: when m_axis_tready=0 and buffers are full, s_axis_tready=0 within the same cycle the last slot fills. No beat is lost or duplicated.
- areset mid-frame: all in-flight pixels dropped immediately and outputs forced to reset values. Resumes in EVEN.

## Test plan
- Neutral grey: beats {U=128,Y=128},{V=128,Y=128} -> two pixels 0x808080, first after 2-cycle latency. Y=255 -> 0xFFFFFF.
- Saturation: Y0=0,U=128,V=255 -> pixel0 = {178,0,0}. Y0=255,U=0,V=0 -> {75,255,28}.
- Line of 640 beats, tuser on beat 0, tlast on beat 639, m_axis_tready=1 -> 640 pixels in 640 consecutive cycles. tuser on pixel 0 only, tlast on pixel 639 only.
- Odd line: 3 beats with tlast on beat 2 (EVEN phase) -> 3 pixels; third uses V=128 and carries tlast; next beat is treated as EVEN.
- Random m_axis_tready (50%) with random s_axis_tvalid over 10 lines -> output sequence matches reference model bit-exactly; data stable under stall.
- tuser on an ODD-phase beat -> held pixel dropped, resync_err=1 and stays 1. Then areset pulse mid-line -> all outputs 0, resync_err=0, and a clean line converts correctly.
